// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding scoreboard: the in-flight
// destination record, the register-file select code and the stage-count limit.
package fwd_pkg;

    localparam int FWD_MAX_STAGES = 6;
    // Widest register address the record can carry.
    localparam int FWD_MAX_AW     = 16;
    localparam int FWD_SEL_RF     = 0;

    typedef struct packed {
        logic                  valid;
        logic [FWD_MAX_AW-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } fwd_rec_t;

    localparam fwd_rec_t FWD_BUBBLE = '0;

    // A record can only be a forwarding source if it really writes a nonzero rd.
    function automatic logic rec_live(input fwd_rec_t rec);
        return rec.valid && rec.regwrite && (rec.rd != '0);
    endfunction

endpackage

// File: rtl/forwarding_scoreboard_if.sv
// ID-side bundle of the forwarding scoreboard: pipeline control, the decoded
// ID instruction, and the hazard / forward-select / counter results.
interface forwarding_scoreboard_if #(
    parameter int AW         = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1)
);

    logic                     stall_i;
    logic                     flush_i;
    logic                     id_valid_i;
    logic [NUM_SRC*AW-1:0]    id_rs_i;
    logic [AW-1:0]            id_rd_i;
    logic                     id_regwrite_i;
    logic                     id_memread_i;
    logic                     hazard_stall_o;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_o;
    logic [31:0]              stall_cnt_o;
    logic [31:0]              fwd_cnt_o;

    modport master (
        output stall_i, flush_i, id_valid_i, id_rs_i, id_rd_i,
               id_regwrite_i, id_memread_i,
        input  hazard_stall_o, fwd_sel_o, stall_cnt_o, fwd_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, id_valid_i, id_rs_i, id_rd_i,
               id_regwrite_i, id_memread_i,
        output hazard_stall_o, fwd_sel_o, stall_cnt_o, fwd_cnt_o
    );

endinterface

// File: rtl/fwd_match.sv
// Compares one source address against the in-flight records (index 0 = EX)
// and returns the stage number of the youngest live producer, or 0.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int AW         = 5,
    parameter int FWD_STAGES = 2,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic [AW-1:0]    rs,
    input  fwd_rec_t         recs [FWD_STAGES],
    output logic [SEL_W-1:0] sel
);

    always_comb begin
        sel = SEL_W'(FWD_SEL_RF);
        // NOTE: blocking assignments in combinational logic; scanning oldest to
        // youngest lets a younger match overwrite an older one.
        for (int j = FWD_STAGES; j >= 1; j--) begin
            if ((rs != '0) && rec_live(recs[j-1]) &&
                (recs[j-1].rd == FWD_MAX_AW'(rs))) begin
                sel = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Shift register of in-flight destination records with registered per-source
// forward selects and load-use hold detection. Optional counters: FWD_PERF_EN.
module forwarding_scoreboard
    import fwd_pkg::*;
#(
    parameter int AW         = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    forwarding_scoreboard_if.slave  bus
);

    // Records for EX and the following stages that can still forward. The
    // record leaving the deepest forwarding stage is never consulted again,
    // so it is not stored.
    fwd_rec_t                 stage [FWD_STAGES];
    fwd_rec_t                 id_rec;
    logic                     src_hit;
    logic                     hazard;
    logic                     load_bubble;
    logic [SEL_W-1:0]         match_sel [NUM_SRC];
    logic [NUM_SRC*SEL_W-1:0] next_sel;
    logic [NUM_SRC*SEL_W-1:0] sel_q;

    // Load-use: a load in EX whose rd is read by the instruction in ID.
    always_comb begin
        src_hit = 1'b0;
        for (int n = 0; n < NUM_SRC; n++) begin
            if (FWD_MAX_AW'(bus.id_rs_i[n*AW +: AW]) == stage[0].rd) begin
                src_hit = 1'b1;
            end
        end
        hazard = bus.id_valid_i && rec_live(stage[0]) && stage[0].memread &&
                 src_hit && !bus.flush_i;
    end

    assign load_bubble = bus.flush_i || hazard || !bus.id_valid_i;

    always_comb begin
        id_rec          = FWD_BUBBLE;
        id_rec.valid    = 1'b1;
        id_rec.rd       = FWD_MAX_AW'(bus.id_rd_i);
        id_rec.regwrite = bus.id_regwrite_i;
        id_rec.memread  = bus.id_memread_i;
    end

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_match
        fwd_match #(
            .AW         (AW),
            .FWD_STAGES (FWD_STAGES)
        ) u_match (
            .rs   (bus.id_rs_i[n*AW +: AW]),
            .recs (stage),
            .sel  (match_sel[n])
        );
    end

    always_comb begin
        next_sel = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            next_sel[n*SEL_W +: SEL_W] = match_sel[n];
        end
    end

    // NOTE: the record array is small and its valid bits must clear on reset,
    // so every entry is reset; non-blocking assignments keep the shift ordered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int j = 0; j < FWD_STAGES; j++) begin
                stage[j] <= FWD_BUBBLE;
            end
            sel_q <= '0;
        end else if (!bus.stall_i) begin
            for (int j = FWD_STAGES - 1; j >= 1; j--) begin
                stage[j] <= stage[j-1];
            end
            stage[0] <= load_bubble ? FWD_BUBBLE : id_rec;
            sel_q    <= load_bubble ? '0 : next_sel;
        end
    end

    assign bus.hazard_stall_o = hazard;
    assign bus.fwd_sel_o      = sel_q;

`ifdef FWD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (!bus.stall_i) begin
            if (hazard && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!load_bubble && (|next_sel) && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end

    assign bus.stall_cnt_o = stall_cnt;
    assign bus.fwd_cnt_o   = fwd_cnt;
`else
    assign bus.stall_cnt_o = '0;
    assign bus.fwd_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Self-checking bench for forwarding_scoreboard: directed pipeline scenarios
// plus randomized traffic against a history-queue reference model.
module tb_forwarding_scoreboard;

    localparam int AW         = 5;
    localparam int NUM_SRC    = 2;
    localparam int FWD_STAGES = 2;
    localparam int SEL_W      = $clog2(FWD_STAGES + 1);
`ifdef FWD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    typedef struct {
        bit valid;
        int rd;
        bit rw;
        bit mr;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    // Reference model: what entered EX on each past advance, newest first.
    ent_t hist[$];
    int   exp_sel [NUM_SRC];
    int   exp_stall_cnt;
    int   exp_fwd_cnt;
    bit   exp_haz;
    logic obs_haz;

    forwarding_scoreboard_if #(
        .AW(AW), .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES)
    ) bus ();

    forwarding_scoreboard #(
        .AW(AW), .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic bit live(input ent_t e);
        return e.valid && e.rw && (e.rd != 0);
    endfunction

    function automatic int src(input int n);
        return int'(bus.id_rs_i[n*AW +: AW]);
    endfunction

    function automatic logic [NUM_SRC*SEL_W-1:0] pack_sel(input int s0, input int s1);
        logic [NUM_SRC*SEL_W-1:0] r;
        r = '0;
        r[0 +: SEL_W]     = SEL_W'(s0);
        r[SEL_W +: SEL_W] = SEL_W'(s1);
        return r;
    endfunction

    function automatic logic [NUM_SRC*SEL_W-1:0] model_sel();
        return pack_sel(exp_sel[0], exp_sel[1]);
    endfunction

    function automatic bit model_hazard();
        ent_t e;
        bit   hit;
        if (!bus.id_valid_i || bus.flush_i || hist.size() == 0) return 1'b0;
        e = hist[0];
        hit = 1'b0;
        for (int n = 0; n < NUM_SRC; n++) if (src(n) == e.rd) hit = 1'b1;
        return live(e) && e.mr && hit;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int n = 0; n < NUM_SRC; n++) exp_sel[n] = 0;
        exp_stall_cnt = 0;
        exp_fwd_cnt   = 0;
    endtask

    // One advance seen from the program's point of view: the new EX occupant
    // forwards from the youngest earlier instruction that wrote its source.
    task automatic model_advance(input bit haz);
        bit   bubble;
        bit   any;
        ent_t e;
        if (bus.stall_i) return;
        bubble = bus.flush_i || haz || !bus.id_valid_i;
        any = 1'b0;
        for (int n = 0; n < NUM_SRC; n++) begin
            exp_sel[n] = 0;
            if (!bubble && src(n) != 0) begin
                for (int k = 0; k < hist.size(); k++) begin
                    if (live(hist[k]) && hist[k].rd == src(n)) begin
                        exp_sel[n] = k + 1;
                        break;
                    end
                end
            end
            if (exp_sel[n] != 0) any = 1'b1;
        end
        if (PERF != 0 && haz) exp_stall_cnt++;
        if (PERF != 0 && any) exp_fwd_cnt++;
        e.valid = !bubble;
        e.rd    = bubble ? 0 : int'(bus.id_rd_i);
        e.rw    = bubble ? 1'b0 : bus.id_regwrite_i;
        e.mr    = bubble ? 1'b0 : bus.id_memread_i;
        hist.push_front(e);
        if (hist.size() > FWD_STAGES) void'(hist.pop_back());
    endtask

    // Drive one cycle of ID-side inputs, sample the hazard before the edge,
    // then advance the model with the edge.
    task automatic apply(input logic v, input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rd, input logic rw, input logic mr,
                         input logic st, input logic fl);
        bus.id_valid_i    = v;
        bus.id_rs_i       = {rs1, rs0};
        bus.id_rd_i       = rd;
        bus.id_regwrite_i = rw;
        bus.id_memread_i  = mr;
        bus.stall_i       = st;
        bus.flush_i       = fl;
        #1;
        exp_haz = model_hazard();
        obs_haz = bus.hazard_stall_o;
        @(posedge clk);
        model_advance(exp_haz);
        #1;
    endtask

    task automatic clear_pipe();
        repeat (FWD_STAGES + 1) apply(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        bus.id_valid_i = 1'b1; bus.id_rs_i = {5'd7, 5'd7}; bus.id_rd_i = 5'd7;
        bus.id_regwrite_i = 1'b1; bus.id_memread_i = 1'b1;
        bus.stall_i = 1'b0; bus.flush_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.fwd_sel_o !== '0) begin errors++; $display("FAIL reset_sel got=%h exp=0", bus.fwd_sel_o); end
        checks++; if (bus.hazard_stall_o !== 1'b0) begin errors++; $display("FAIL reset_haz got=%b exp=0", bus.hazard_stall_o); end
        checks++; if (bus.stall_cnt_o !== 32'd0 || bus.fwd_cnt_o !== 32'd0) begin
            errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.stall_cnt_o, bus.fwd_cnt_o); end
        rst = 1'b0;
        #2;
    endtask

    task automatic test_load_use();
        clear_pipe();
        apply(1, 1, 2, 7, 1, 1, 0, 0);           // lw r7
        apply(1, 7, 0, 9, 1, 0, 0, 0);           // consumer of r7
        checks++; if (obs_haz !== 1'b1) begin errors++; $display("FAIL lu_haz got=%b exp=1", obs_haz); end
        checks++; if (bus.fwd_sel_o !== '0) begin errors++; $display("FAIL lu_bubble got=%h exp=0", bus.fwd_sel_o); end
        checks++; if (bus.stall_cnt_o !== 32'(PERF)) begin
            errors++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", bus.stall_cnt_o, PERF); end
        apply(1, 7, 0, 9, 1, 0, 0, 0);           // retried consumer
        checks++; if (obs_haz !== 1'b0) begin errors++; $display("FAIL lu_retry_haz got=%b exp=0", obs_haz); end
        checks++; if (bus.fwd_sel_o !== pack_sel(2, 0)) begin
            errors++; $display("FAIL lu_retry_sel got=%h exp=%h", bus.fwd_sel_o, pack_sel(2, 0)); end
        checks++; if (bus.fwd_cnt_o !== 32'(PERF)) begin
            errors++; $display("FAIL lu_fwd_cnt got=%0d exp=%0d", bus.fwd_cnt_o, PERF); end
    endtask

    task automatic test_back_to_back();
        clear_pipe();
        apply(1, 1, 2, 3, 1, 0, 0, 0);           // add r3
        apply(1, 3, 4, 6, 1, 0, 0, 0);           // sub r6, r3, r4
        checks++; if (obs_haz !== 1'b0) begin errors++; $display("FAIL b2b_haz got=%b exp=0", obs_haz); end
        checks++; if (bus.fwd_sel_o !== pack_sel(1, 0)) begin
            errors++; $display("FAIL b2b_sel got=%h exp=%h", bus.fwd_sel_o, pack_sel(1, 0)); end
    endtask

    task automatic test_distance_two();
        clear_pipe();
        apply(1, 1, 2, 5, 1, 0, 0, 0);           // producer r5
        apply(1, 1, 2, 8, 1, 0, 0, 0);           // unrelated
        apply(1, 9, 5, 10, 1, 0, 0, 0);          // consumer, r5 as source 1
        checks++; if (bus.fwd_sel_o !== pack_sel(0, 2)) begin
            errors++; $display("FAIL dist2_sel got=%h exp=%h", bus.fwd_sel_o, pack_sel(0, 2)); end
    endtask

    task automatic test_youngest();
        clear_pipe();
        apply(1, 1, 2, 4, 1, 0, 0, 0);
        apply(1, 1, 2, 4, 1, 0, 0, 0);
        apply(1, 4, 4, 11, 1, 0, 0, 0);
        checks++; if (bus.fwd_sel_o !== pack_sel(1, 1)) begin
            errors++; $display("FAIL youngest_sel got=%h exp=%h", bus.fwd_sel_o, pack_sel(1, 1)); end
    endtask

    task automatic test_r0();
        clear_pipe();
        apply(1, 1, 2, 0, 1, 1, 0, 0);           // load into r0
        apply(1, 0, 0, 12, 1, 0, 0, 0);          // reads r0 twice
        checks++; if (obs_haz !== 1'b0) begin errors++; $display("FAIL r0_haz got=%b exp=0", obs_haz); end
        checks++; if (bus.fwd_sel_o !== pack_sel(0, 0)) begin
            errors++; $display("FAIL r0_sel got=%h exp=%h", bus.fwd_sel_o, pack_sel(0, 0)); end
    endtask

    task automatic test_flush_hazard();
        clear_pipe();
        apply(1, 1, 2, 7, 1, 1, 0, 0);           // lw r7
        apply(1, 7, 0, 9, 1, 0, 0, 1);           // consumer killed by flush
        checks++; if (obs_haz !== 1'b0) begin errors++; $display("FAIL flush_haz got=%b exp=0", obs_haz); end
        checks++; if (bus.fwd_sel_o !== '0) begin errors++; $display("FAIL flush_sel got=%h exp=0", bus.fwd_sel_o); end
        apply(1, 7, 0, 9, 1, 0, 0, 0);           // load now sits behind a bubble
        checks++; if (bus.fwd_sel_o !== pack_sel(2, 0)) begin
            errors++; $display("FAIL flush_after_sel got=%h exp=%h", bus.fwd_sel_o, pack_sel(2, 0)); end
        checks++; if (bus.stall_cnt_o !== 32'(exp_stall_cnt)) begin
            errors++; $display("FAIL flush_stall_cnt got=%0d exp=%0d", bus.stall_cnt_o, exp_stall_cnt); end
    endtask

    task automatic test_stall_hold();
        clear_pipe();
        apply(1, 1, 2, 3, 1, 0, 0, 0);           // producer r3
        apply(1, 3, 0, 6, 1, 0, 0, 0);           // consumer r3
        for (int i = 0; i < 3; i++) begin
            apply(1, 6, 3, 5, 1, 1, 1, 0);       // frozen; ID offers a load of r5
            checks++; if (bus.fwd_sel_o !== pack_sel(1, 0)) begin
                errors++; $display("FAIL stall_hold_sel cyc=%0d got=%h exp=%h", i, bus.fwd_sel_o, pack_sel(1, 0)); end
        end
        apply(1, 3, 5, 9, 1, 0, 0, 0);
        checks++; if (bus.fwd_sel_o !== pack_sel(2, 0)) begin
            errors++; $display("FAIL stall_resume_sel got=%h exp=%h", bus.fwd_sel_o, pack_sel(2, 0)); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(logic'($urandom_range(0, 9) != 0),
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) == 0),
                  logic'($urandom_range(0, 6) == 0), logic'($urandom_range(0, 9) == 0));
            checks++; if (obs_haz !== exp_haz) begin
                errors++; $display("FAIL rnd_haz cyc=%0d got=%b exp=%b", i, obs_haz, exp_haz); end
            checks++; if (bus.fwd_sel_o !== model_sel()) begin
                errors++; $display("FAIL rnd_sel cyc=%0d got=%h exp=%h", i, bus.fwd_sel_o, model_sel()); end
            checks++; if (bus.stall_cnt_o !== 32'(exp_stall_cnt)) begin
                errors++; $display("FAIL rnd_stall_cnt cyc=%0d got=%0d exp=%0d", i, bus.stall_cnt_o, exp_stall_cnt); end
            checks++; if (bus.fwd_cnt_o !== 32'(exp_fwd_cnt)) begin
                errors++; $display("FAIL rnd_fwd_cnt cyc=%0d got=%0d exp=%0d", i, bus.fwd_cnt_o, exp_fwd_cnt); end
        end
    endtask

    task automatic test_reset_midstream();
        clear_pipe();
        apply(1, 1, 2, 3, 1, 0, 0, 0);           // producer r3
        apply(1, 3, 0, 6, 1, 0, 0, 0);           // consumer r3
        apply(1, 3, 0, 7, 1, 1, 0, 0);           // lw r7 reading r3 from stage 2
        checks++; if (bus.fwd_sel_o !== pack_sel(2, 0)) begin
            errors++; $display("FAIL mid_pre_sel got=%h exp=%h", bus.fwd_sel_o, pack_sel(2, 0)); end
        bus.id_valid_i = 1'b1; bus.id_rs_i = {5'd0, 5'd7}; bus.id_rd_i = 5'd9;
        bus.id_regwrite_i = 1'b1; bus.id_memread_i = 1'b0;
        #1;
        checks++; if (bus.hazard_stall_o !== 1'b1) begin
            errors++; $display("FAIL mid_pre_haz got=%b exp=1", bus.hazard_stall_o); end
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if (bus.fwd_sel_o !== '0 || bus.hazard_stall_o !== 1'b0) begin
            errors++; $display("FAIL mid_rst_out got=%h/%b exp=0/0", bus.fwd_sel_o, bus.hazard_stall_o); end
        checks++; if (bus.stall_cnt_o !== 32'd0 || bus.fwd_cnt_o !== 32'd0) begin
            errors++; $display("FAIL mid_rst_cnt got=%0d/%0d exp=0/0", bus.stall_cnt_o, bus.fwd_cnt_o); end
        #1;
        rst = 1'b0;
        apply(1, 1, 2, 3, 1, 0, 0, 0);
        apply(1, 3, 0, 6, 1, 0, 0, 0);
        checks++; if (bus.fwd_sel_o !== pack_sel(1, 0)) begin
            errors++; $display("FAIL mid_post_sel got=%h exp=%h", bus.fwd_sel_o, pack_sel(1, 0)); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_back_to_back();
        test_distance_two();
        test_youngest();
        test_r0();
        test_flush_hazard();
        test_stall_hold();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
